// File: rtl/sccb_target_if.sv
// sccb_target_if
// Groups the SCCB pins and the register-side port of the SCCB target.
//   scl, sda_in  : bus pins as seen by the target (asynchronous to the system clock)
//   sda_oe       : 1 = pad pulls SDA low, 0 = SDA released
//   reg_addr     : register sub-address
//   reg_wdata    : write data, valid while reg_we = 1
//   reg_we       : one-cycle register write strobe
//   reg_rdata    : read data for reg_addr
//   busy         : high from a START to the next STOP
// Modports: slave = the target device, master = the bus/register environment around it.
interface sccb_target_if;
    logic       scl;
    logic       sda_in;
    logic       sda_oe;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic [7:0] reg_rdata;
    logic       busy;

    modport slave (
        input  scl, sda_in, reg_rdata,
        output sda_oe, reg_addr, reg_wdata, reg_we, busy
    );

    modport master (
        output scl, sda_in, reg_rdata,
        input  sda_oe, reg_addr, reg_wdata, reg_we, busy
    );
endinterface

// File: rtl/sccb_target.sv
// sccb_target
// SCCB target (slave). Oversamples SCL/SDA with clk_25M, decodes 3-phase writes
// (ID, sub-address, data...) and 2-phase reads (ID, data...) and maps them onto
// an 8-bit register port. Write ID is DEVICE_ID, read ID is DEVICE_ID | 1.
// Ports:
//   clk_25M : 25 MHz system clock
//   rst_n   : asynchronous active-low reset
//   bus     : sccb_target_if.slave (scl, sda_in, sda_oe, reg_addr, reg_wdata,
//             reg_we, reg_rdata, busy)
// Optional feature: define SCCB_ACK_EN to drive an I2C-style ACK (SDA low) in the
// ninth bit after a matching ID, the sub-address and every written data byte.
// Without it the ninth bit is left to the pull-up.
module sccb_target #(
    parameter logic [7:0] DEVICE_ID = 8'h42
) (
    input  logic           clk_25M,
    input  logic           rst_n,
    sccb_target_if.slave   bus
);

    localparam logic [3:0] ST_IDLE    = 4'd0;
    localparam logic [3:0] ST_ID      = 4'd1;
    localparam logic [3:0] ST_ID_X    = 4'd2;
    localparam logic [3:0] ST_SUB     = 4'd3;
    localparam logic [3:0] ST_SUB_X   = 4'd4;
    localparam logic [3:0] ST_WDATA   = 4'd5;
    localparam logic [3:0] ST_WDATA_X = 4'd6;
    localparam logic [3:0] ST_RDATA   = 4'd7;
    localparam logic [3:0] ST_RDATA_X = 4'd8;
    localparam logic [3:0] ST_IGNORE  = 4'd9;

    localparam logic [7:0] READ_ID = DEVICE_ID | 8'h01;

    // Synchroniser chains: stage 2 is the synced value, stage 3 its previous value.
    logic scl_s1_r, scl_s2_r, scl_s3_r;
    logic sda_s1_r, sda_s2_r, sda_s3_r;

    logic [3:0] state_r;
    logic [2:0] bit_cnt_r;
    logic [7:0] shift_r;
    logic       sda_oe_r;
    logic       reg_we_r;
    logic       busy_r;
    logic [7:0] reg_addr_r;
    logic [7:0] reg_wdata_r;

    logic       scl_rise_s;
    logic       scl_fall_s;
    logic       start_s;
    logic       stop_s;
    logic       last_bit_s;
    logic [7:0] byte_s;
    logic       ack_drive_s;

    assign scl_rise_s = scl_s2_r & ~scl_s3_r;
    assign scl_fall_s = ~scl_s2_r & scl_s3_r;
    // SDA edges only count as START/STOP while SCL is stable high.
    assign start_s    = scl_s2_r & scl_s3_r & sda_s3_r & ~sda_s2_r;
    assign stop_s     = scl_s2_r & scl_s3_r & ~sda_s3_r & sda_s2_r;
    assign last_bit_s = (bit_cnt_r == 3'd7);
    // Byte including the bit being sampled on this rising edge.
    assign byte_s     = {shift_r[6:0], sda_s2_r};

`ifdef SCCB_ACK_EN
    // In ID_X the shift register still holds the received ID byte.
    assign ack_drive_s = ((state_r == ST_ID_X) && ((shift_r == DEVICE_ID) || (shift_r == READ_ID)))
                       || (state_r == ST_SUB_X) || (state_r == ST_WDATA_X);
`else
    assign ack_drive_s = 1'b0;
`endif

    assign bus.sda_oe    = sda_oe_r;
    assign bus.reg_we    = reg_we_r;
    assign bus.busy      = busy_r;
    assign bus.reg_addr  = reg_addr_r;
    assign bus.reg_wdata = reg_wdata_r;

    // Two-flop synchronisers plus an edge-detect flop; idle bus level is 1.
    always_ff @(posedge clk_25M or negedge rst_n) begin
        if (!rst_n) begin
            scl_s1_r <= 1'b1;
            scl_s2_r <= 1'b1;
            scl_s3_r <= 1'b1;
            sda_s1_r <= 1'b1;
            sda_s2_r <= 1'b1;
            sda_s3_r <= 1'b1;
        end else begin
            scl_s1_r <= bus.scl;
            scl_s2_r <= scl_s1_r;
            scl_s3_r <= scl_s2_r;
            sda_s1_r <= bus.sda_in;
            sda_s2_r <= sda_s1_r;
            sda_s3_r <= sda_s2_r;
        end
    end

    // Protocol FSM: START/STOP override everything, bits sampled on SCL rise, SDA driven on SCL fall.
    always_ff @(posedge clk_25M or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            bit_cnt_r   <= 3'd0;
            shift_r     <= 8'h00;
            sda_oe_r    <= 1'b0;
            reg_we_r    <= 1'b0;
            busy_r      <= 1'b0;
            reg_addr_r  <= 8'h00;
            reg_wdata_r <= 8'h00;
        end else begin
            reg_we_r <= 1'b0;
            // Address advances in the cycle after each write strobe (wraps FF -> 00).
            if (reg_we_r) begin
                reg_addr_r <= reg_addr_r + 8'd1;
            end

            if (start_s) begin
                state_r   <= ST_ID;
                bit_cnt_r <= 3'd0;
                busy_r    <= 1'b1;
                sda_oe_r  <= 1'b0;
            end else if (stop_s) begin
                state_r   <= ST_IDLE;
                bit_cnt_r <= 3'd0;
                busy_r    <= 1'b0;
                sda_oe_r  <= 1'b0;
            end else if (scl_rise_s) begin
                case (state_r)
                    ST_ID, ST_SUB, ST_WDATA: begin
                        shift_r <= byte_s;
                        if (last_bit_s) begin
                            bit_cnt_r <= 3'd0;
                            if (state_r == ST_ID) begin
                                state_r <= ST_ID_X;
                            end else if (state_r == ST_SUB) begin
                                reg_addr_r <= byte_s;
                                state_r    <= ST_SUB_X;
                            end else begin
                                reg_wdata_r <= byte_s;
                                reg_we_r    <= 1'b1;
                                state_r     <= ST_WDATA_X;
                            end
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 3'd1;
                        end
                    end
                    ST_ID_X: begin
                        bit_cnt_r <= 3'd0;
                        if (shift_r == DEVICE_ID) begin
                            state_r <= ST_SUB;
                        end else if (shift_r == READ_ID) begin
                            state_r <= ST_RDATA;
                        end else begin
                            state_r <= ST_IGNORE;
                        end
                    end
                    ST_SUB_X, ST_WDATA_X: begin
                        bit_cnt_r <= 3'd0;
                        state_r   <= ST_WDATA;
                    end
                    ST_RDATA: begin
                        // Rising edges here are the master sampling our bits; just count them.
                        if (last_bit_s) begin
                            bit_cnt_r <= 3'd0;
                            state_r   <= ST_RDATA_X;
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 3'd1;
                        end
                    end
                    ST_RDATA_X: begin
                        bit_cnt_r <= 3'd0;
                        if (sda_s2_r) begin
                            state_r <= ST_IGNORE;
                        end else begin
                            reg_addr_r <= reg_addr_r + 8'd1;
                            state_r    <= ST_RDATA;
                        end
                    end
                    default: begin
                        state_r <= state_r;
                    end
                endcase
            end else if (scl_fall_s) begin
                case (state_r)
                    ST_RDATA: begin
                        // First fall of a read byte loads fresh register data.
                        if (bit_cnt_r == 3'd0) begin
                            sda_oe_r <= ~bus.reg_rdata[7];
                            shift_r  <= {bus.reg_rdata[6:0], 1'b0};
                        end else begin
                            sda_oe_r <= ~shift_r[7];
                            shift_r  <= {shift_r[6:0], 1'b0};
                        end
                    end
                    ST_ID_X, ST_SUB_X, ST_WDATA_X: begin
                        sda_oe_r <= ack_drive_s;
                    end
                    default: begin
                        sda_oe_r <= 1'b0;
                    end
                endcase
            end else begin
                state_r <= state_r;
            end
        end
    end

endmodule

// File: tb/tb_sccb_target.sv
module tb_sccb_target;
    localparam int         Q   = 6;
    localparam logic [7:0] DEV = 8'h42;

    typedef logic [0:3][7:0] bytes4_t;
    typedef struct packed { logic [7:0] a; logic [7:0] d; } wr_t;
    typedef struct {
        int         n;
        bytes4_t    b;
        int         exp_cnt;
        logic [7:0] exp_end;
    } vec_t;

    logic clk_25M = 1'b0;
    logic rst_n   = 1'b0;
    logic scl_m   = 1'b1;
    logic sda_m   = 1'b1;

    int         total = 0;
    int         bad   = 0;
    int         oe_cycles = 0;
    wr_t        got_q[$];
    logic [7:0] model_addr = 8'h00;

    sccb_target_if bus();
    sccb_target #(.DEVICE_ID(DEV)) dut (.clk_25M(clk_25M), .rst_n(rst_n), .bus(bus));

    always #20 clk_25M = ~clk_25M;

    // Open-drain bus: either side can pull SDA low. Register file content is addr ^ 0xAF.
    assign bus.scl       = scl_m;
    assign bus.sda_in    = sda_m & ~bus.sda_oe;
    assign bus.reg_rdata = bus.reg_addr ^ 8'hAF;

    // Record every write strobe cycle and every cycle SDA is pulled by the target.
    always @(negedge clk_25M) begin
        if (bus.reg_we) got_q.push_back('{a: bus.reg_addr, d: bus.reg_wdata});
        if (bus.sda_oe) oe_cycles++;
    end

    initial begin
        repeat (90000) @(posedge clk_25M);
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    // Expected level of the ninth bit seen by the master.
    function automatic logic exp_ack(input logic matched);
`ifdef SCCB_ACK_EN
        return ~matched;
`else
        return 1'b1 | matched;
`endif
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk_25M);
    endtask

    task automatic bus_start();
        sda_m = 1'b1; tick(Q);
        scl_m = 1'b1; tick(Q);
        sda_m = 1'b0; tick(Q);
        scl_m = 1'b0;
    endtask

    task automatic bus_stop();
        tick(Q); sda_m = 1'b0;
        tick(Q); scl_m = 1'b1;
        tick(Q); sda_m = 1'b1;
        tick(2 * Q);
    endtask

    task automatic send_bit(input logic b);
        tick(Q); sda_m = b;
        tick(Q); scl_m = 1'b1;
        tick(2 * Q); scl_m = 1'b0;
    endtask

    task automatic recv_bit(output logic b);
        tick(Q); sda_m = 1'b1;
        tick(Q); scl_m = 1'b1;
        tick(Q); b = bus.sda_in;
        tick(Q); scl_m = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        recv_bit(ack);
    endtask

    task automatic recv_byte(output logic [7:0] d, input logic na);
        logic bv;
        for (int i = 7; i >= 0; i--) begin
            recv_bit(bv);
            d[i] = bv;
        end
        send_bit(na);
    endtask

    // Full write transaction checked against the transaction-level model.
    task automatic do_write(input int n, input bytes4_t b, output int nwr);
        wr_t  exp_q[$];
        int   wr0, oe0;
        logic ack, matched;
        wr0 = got_q.size();
        oe0 = oe_cycles;
        matched = (b[0] == DEV);
        if (matched && n >= 2) begin
            model_addr = b[1];
            for (int i = 2; i < n; i++) begin
                exp_q.push_back('{a: model_addr, d: b[i]});
                model_addr = model_addr + 8'd1;
            end
        end
        bus_start();
        tick(Q);
        check("busy_after_start", bus.busy, 1);
        for (int i = 0; i < n; i++) begin
            send_byte(b[i], ack);
            check("ninth_bit", ack, exp_ack(matched));
        end
        bus_stop();
        tick(4);
        nwr = got_q.size() - wr0;
        check("write_count", nwr, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < nwr) begin
                check("write_addr", got_q[wr0 + i].a, exp_q[i].a);
                check("write_data", got_q[wr0 + i].d, exp_q[i].d);
            end
        end
        check("write_end_addr", bus.reg_addr, model_addr);
        check("busy_after_stop", bus.busy, 0);
        if (!matched) check("ignore_no_drive", oe_cycles - oe0, 0);
    endtask

    task automatic do_read(input int nb, output logic [7:0] first);
        int         wr0;
        logic       ack;
        logic [7:0] d;
        first = 8'h00;
        wr0 = got_q.size();
        bus_start();
        send_byte(DEV | 8'h01, ack);
        check("read_id_ninth_bit", ack, exp_ack(1'b1));
        for (int k = 0; k < nb; k++) begin
            recv_byte(d, (k == nb - 1));
            check("read_data", d, model_addr ^ 8'hAF);
            if (k == 0) first = d;
            if (k != nb - 1) model_addr = model_addr + 8'd1;
        end
        bus_stop();
        tick(4);
        check("read_no_we", got_q.size() - wr0, 0);
        check("read_end_addr", bus.reg_addr, model_addr);
        check("read_busy_clear", bus.busy, 0);
    endtask

    initial begin
        vec_t       tbl[5];
        int         nwr, wr0, n;
        logic       ack;
        logic [7:0] rd, id;
        bytes4_t    rb;

        tbl[0].n = 3; tbl[0].b = {8'h42, 8'h12, 8'h80, 8'h00}; tbl[0].exp_cnt = 1; tbl[0].exp_end = 8'h13;
        tbl[1].n = 4; tbl[1].b = {8'h42, 8'hFF, 8'h11, 8'h22}; tbl[1].exp_cnt = 2; tbl[1].exp_end = 8'h01;
        tbl[2].n = 3; tbl[2].b = {8'h40, 8'h12, 8'h80, 8'h00}; tbl[2].exp_cnt = 0; tbl[2].exp_end = 8'h01;
        tbl[3].n = 3; tbl[3].b = {8'h42, 8'h34, 8'h56, 8'h00}; tbl[3].exp_cnt = 1; tbl[3].exp_end = 8'h35;
        tbl[4].n = 2; tbl[4].b = {8'h42, 8'h0A, 8'h00, 8'h00}; tbl[4].exp_cnt = 0; tbl[4].exp_end = 8'h0A;

        // Reset state
        tick(5);
        check("rst_sda_oe", bus.sda_oe, 0);
        check("rst_reg_we", bus.reg_we, 0);
        check("rst_reg_addr", bus.reg_addr, 0);
        check("rst_reg_wdata", bus.reg_wdata, 0);
        check("rst_busy", bus.busy, 0);
        rst_n = 1'b1;
        tick(5);

        // Directed write vectors with hand-derived strobe counts and final addresses
        for (int v = 0; v < 5; v++) begin
            do_write(tbl[v].n, tbl[v].b, nwr);
            check("tbl_count", nwr, tbl[v].exp_cnt);
            check("tbl_end_addr", bus.reg_addr, tbl[v].exp_end);
        end
        // Wrapped second strobe of vector 1 lands on address 0x00 with data 0x22
        check("wrap_addr", got_q[2].a, 8'h00);
        check("wrap_data", got_q[2].d, 8'h22);

        // Read 0x43 from 0x0A with NA: data 0xA5 = bits 1,0,1,0,0,1,0,1
        do_read(1, rd);
        check("read_a5", rd, 8'hA5);
        // Burst read with master ACKs, address advances per acknowledged byte
        do_read(3, rd);

        // STOP after four data bits: partial byte discarded
        wr0 = got_q.size();
        bus_start();
        send_byte(8'h42, ack);
        send_byte(8'h12, ack);
        model_addr = 8'h12;
        for (int i = 0; i < 4; i++) send_bit(i[0]);
        bus_stop();
        tick(4);
        check("partial_no_we", got_q.size() - wr0, 0);
        check("partial_addr", bus.reg_addr, 8'h12);
        check("partial_busy", bus.busy, 0);
        do_write(3, {8'h42, 8'h12, 8'h80, 8'h00}, nwr);

        // Reset pulsed mid-byte
        wr0 = got_q.size();
        bus_start();
        send_byte(8'h42, ack);
        send_byte(8'h12, ack);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        rst_n = 1'b0;
        tick(2);
        check("midrst_addr", bus.reg_addr, 0);
        check("midrst_busy", bus.busy, 0);
        check("midrst_sda_oe", bus.sda_oe, 0);
        rst_n = 1'b1;
        model_addr = 8'h00;
        bus_stop();
        tick(4);
        check("midrst_no_we", got_q.size() - wr0, 0);
        do_write(3, {8'h42, 8'h77, 8'h99, 8'h00}, nwr);

        // Randomised transactions against the model
        for (int r = 0; r < 16; r++) begin
            if ($urandom_range(0, 2) < 2) begin
                id = ($urandom_range(0, 3) == 0) ? 8'($urandom) : DEV;
                if (id == (DEV | 8'h01)) id = DEV;
                n  = $urandom_range(1, 4);
                rb = {id, 8'($urandom), 8'($urandom), 8'($urandom)};
                do_write(n, rb, nwr);
            end else begin
                do_read($urandom_range(1, 3), rd);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
